// File: rtl/pipe_flow_ctrl.sv
// pipe_flow_ctrl: central enable/clear controller for the five-stage
// pipeline. It merges the hazard stall, the multiply/divide busy window and
// the CP0 exception/interrupt request into per-stage-register controls. It
// also owns the MDU busy counter and a saturating stalled-cycle counter.
module pipe_flow_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hz_stall,
  input  logic             D_md_use,
  input  logic             E_md_start,
  input  logic             E_md_div,
  input  logic             req,
  output logic             F_en,
  output logic             FD_en,
  output logic             FD_clr,
  output logic             DE_clr,
  output logic             EM_clr,
  output logic             MW_req,
  output logic             md_start_q,
  output logic             md_busy,
  output logic [CNT_W-1:0] md_cnt,
  output logic [31:0]      stall_cycles
);

  // Reload values for the busy counter, sized to the counter width.
  localparam logic [CNT_W-1:0] MULT_LD  = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LD   = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [31:0]      STALL_MAX = 32'hFFFF_FFFF;

  logic [CNT_W-1:0] md_cnt_r;
  logic [31:0]      stall_cycles_r;
  logic             md_start_q_s;
  logic             md_busy_s;
  logic             md_stall_s;
  logic             stall_s;

  // Qualified MDU start, busy flag and the merged stall decision.
  // A flushed instruction must never start the MDU, and a flush overrides
  // any stall in the same cycle.
  always_comb begin
    md_start_q_s = 1'b0;
    md_busy_s    = 1'b0;
    md_stall_s   = 1'b0;
    stall_s      = 1'b0;
    md_start_q_s = E_md_start & ~req;
    if (md_cnt_r != CNT_ZERO) begin
      md_busy_s = 1'b1;
    end else begin
      md_busy_s = 1'b0;
    end
    md_stall_s = D_md_use & (md_busy_s | md_start_q_s);
    stall_s    = (hz_stall | md_stall_s) & ~req;
  end

  // Pipeline register controls, with priority flush > stall > normal.
  always_comb begin
    F_en   = 1'b1;
    FD_en  = 1'b1;
    FD_clr = 1'b0;
    DE_clr = 1'b0;
    EM_clr = 1'b0;
    MW_req = 1'b0;
    if (req) begin
      // Flush: PC loads the handler address, all younger stages cleared.
      F_en   = 1'b1;
      FD_en  = 1'b1;
      FD_clr = 1'b1;
      DE_clr = 1'b1;
      EM_clr = 1'b1;
      MW_req = 1'b1;
    end else if (stall_s) begin
      // Freeze F and D, inject a bubble into E; E, M, W keep draining.
      F_en   = 1'b0;
      FD_en  = 1'b0;
      FD_clr = 1'b0;
      DE_clr = 1'b1;
      EM_clr = 1'b0;
      MW_req = 1'b0;
    end else begin
      F_en   = 1'b1;
      FD_en  = 1'b1;
      FD_clr = 1'b0;
      DE_clr = 1'b0;
      EM_clr = 1'b0;
      MW_req = 1'b0;
    end
  end

  // MDU busy counter: load on a qualified start, otherwise count down to 0.
  // A start while already busy simply reloads; an in-flight operation keeps
  // counting through a flush because it was issued before the fault.
  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt_r <= CNT_ZERO;
    end else if (md_start_q_s) begin
      if (E_md_div) begin
        md_cnt_r <= DIV_LD;
      end else begin
        md_cnt_r <= MULT_LD;
      end
    end else if (md_cnt_r != CNT_ZERO) begin
      md_cnt_r <= md_cnt_r - CNT_ONE;
    end else begin
      md_cnt_r <= md_cnt_r;
    end
  end

  // Saturating count of stalled cycles; flush cycles are not stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_r <= 32'd0;
    end else if (stall_s && (stall_cycles_r != STALL_MAX)) begin
      stall_cycles_r <= stall_cycles_r + 32'd1;
    end else begin
      stall_cycles_r <= stall_cycles_r;
    end
  end

  // Drive the status outputs from the internal state.
  always_comb begin
    md_start_q   = md_start_q_s;
    md_busy      = md_busy_s;
    md_cnt       = md_cnt_r;
    stall_cycles = stall_cycles_r;
  end

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Self-checking bench for pipe_flow_ctrl. The reference model tracks the
// absolute cycle at which the MDU becomes free and a plain stall tally.
module tb_pipe_flow_ctrl;

  logic        clk;
  logic        reset;
  logic        hz_stall;
  logic        D_md_use;
  logic        E_md_start;
  logic        E_md_div;
  logic        req;
  logic        F_en;
  logic        FD_en;
  logic        FD_clr;
  logic        DE_clr;
  logic        EM_clr;
  logic        MW_req;
  logic        md_start_q;
  logic        md_busy;
  logic [3:0]  md_cnt;
  logic [31:0] stall_cycles;

  int          errors;
  int          checks;
  int          cyc;
  int          m_free_at;
  logic [31:0] m_stall;

  pipe_flow_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .hz_stall(hz_stall), .D_md_use(D_md_use),
    .E_md_start(E_md_start), .E_md_div(E_md_div), .req(req),
    .F_en(F_en), .FD_en(FD_en), .FD_clr(FD_clr), .DE_clr(DE_clr),
    .EM_clr(EM_clr), .MW_req(MW_req), .md_start_q(md_start_q),
    .md_busy(md_busy), .md_cnt(md_cnt), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Remaining MDU busy cycles implied by the model.
  function automatic int model_rem();
    return (m_free_at > cyc) ? (m_free_at - cyc) : 0;
  endfunction

  // Whether the pipeline should stall given the current inputs.
  function automatic logic model_stall();
    logic sq;
    sq = E_md_start && !req;
    return (hz_stall || (D_md_use && (model_rem() != 0 || sq))) && !req;
  endfunction

  // Expected {F_en,FD_en,FD_clr,DE_clr,EM_clr,MW_req,md_start_q,md_busy}.
  function automatic logic [7:0] model_ctrl();
    logic st;
    st = model_stall();
    if (req) return {6'b111111, 1'b0, model_rem() != 0};
    return {!st, !st, 1'b0, st, 1'b0, 1'b0, E_md_start, model_rem() != 0};
  endfunction

  task automatic drive(input logic hz, input logic use_i, input logic st,
                       input logic dv, input logic rq);
    hz_stall = hz; D_md_use = use_i; E_md_start = st; E_md_div = dv; req = rq;
    #1;
  endtask

  // Advance one clock edge and update the model from the pre-edge inputs.
  task automatic tick();
    logic sq;
    logic st;
    sq = E_md_start && !req;
    st = model_stall();
    @(posedge clk);
    cyc++;
    if (reset) begin
      m_free_at = cyc;
      m_stall   = 32'd0;
    end else begin
      if (sq) m_free_at = cyc + (E_md_div ? 10 : 5);
      if (st && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    checks++;
    if ({F_en, FD_en, FD_clr, DE_clr, EM_clr, MW_req} !== 6'b110000) begin
      errors++;
      $display("FAIL reset_ctrl got=%b exp=110000", {F_en, FD_en, FD_clr, DE_clr, EM_clr, MW_req});
    end
    checks++;
    if (md_cnt !== 4'd0 || md_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_md got cnt=%0d busy=%b exp cnt=0 busy=0", md_cnt, md_busy);
    end
    checks++;
    if (stall_cycles !== 32'd0) begin
      errors++;
      $display("FAIL reset_stall_cycles got=%0d exp=0", stall_cycles);
    end
  endtask

  task automatic test_hz_stall();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0);
      checks++;
      if ({F_en, FD_en, DE_clr, EM_clr, MW_req} !== 5'b00100) begin
        errors++;
        $display("FAIL hz_stall_ctrl[%0d] got=%b exp=00100", i, {F_en, FD_en, DE_clr, EM_clr, MW_req});
      end
      tick();
    end
    drive(0, 0, 0, 0, 0);
    checks++;
    if (stall_cycles !== 32'd3) begin
      errors++;
      $display("FAIL hz_stall_count got=%0d exp=3", stall_cycles);
    end
  endtask

  task automatic test_div_stall();
    logic [31:0] base;
    base = stall_cycles;
    drive(0, 1, 1, 1, 0);
    checks++;
    if (F_en !== 1'b0 || md_start_q !== 1'b1) begin
      errors++;
      $display("FAIL div_start got F_en=%b start_q=%b exp F_en=0 start_q=1", F_en, md_start_q);
    end
    tick();
    for (int k = 0; k < 10; k++) begin
      drive(0, 1, 0, 0, 0);
      checks++;
      if (md_cnt !== 4'(10 - k) || F_en !== 1'b0 || md_busy !== 1'b1) begin
        errors++;
        $display("FAIL div_count[%0d] got cnt=%0d F_en=%b busy=%b exp cnt=%0d F_en=0 busy=1",
                 k, md_cnt, F_en, md_busy, 10 - k);
      end
      tick();
    end
    checks++;
    if (md_cnt !== 4'd0 || F_en !== 1'b1 || stall_cycles !== base + 32'd11) begin
      errors++;
      $display("FAIL div_release got cnt=%0d F_en=%b stalls=%0d exp cnt=0 F_en=1 stalls=%0d",
               md_cnt, F_en, stall_cycles, base + 32'd11);
    end
  endtask

  task automatic test_mult_no_use();
    int busy_n;
    int stall_seen;
    logic [31:0] base;
    base = stall_cycles;
    busy_n = 0;
    stall_seen = 0;
    drive(0, 0, 1, 0, 0);
    tick();
    for (int k = 0; k < 8; k++) begin
      drive(0, 0, 0, 0, 0);
      if (md_busy === 1'b1) busy_n++;
      if (F_en !== 1'b1) stall_seen++;
      tick();
    end
    checks++;
    if (busy_n != 5 || stall_seen != 0) begin
      errors++;
      $display("FAIL mult_busy got busy=%0d stalls=%0d exp busy=5 stalls=0", busy_n, stall_seen);
    end
    checks++;
    if (stall_cycles !== base) begin
      errors++;
      $display("FAIL mult_stall_count got=%0d exp=%0d", stall_cycles, base);
    end
  endtask

  task automatic test_flush();
    logic [31:0] base;
    base = stall_cycles;
    drive(1, 1, 1, 1, 1);
    checks++;
    if ({F_en, FD_en, FD_clr, DE_clr, EM_clr, MW_req, md_start_q} !== 7'b1111110) begin
      errors++;
      $display("FAIL flush_ctrl got=%b exp=1111110",
               {F_en, FD_en, FD_clr, DE_clr, EM_clr, MW_req, md_start_q});
    end
    tick();
    drive(0, 0, 0, 0, 0);
    checks++;
    if (md_cnt !== 4'd0 || stall_cycles !== base) begin
      errors++;
      $display("FAIL flush_state got cnt=%0d stalls=%0d exp cnt=0 stalls=%0d", md_cnt, stall_cycles, base);
    end
  endtask

  task automatic test_req_busy_reset();
    drive(0, 0, 1, 1, 0);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 0, 0, (k >= 2) ? 1'b1 : 1'b0);
      checks++;
      if (md_cnt !== 4'(10 - k)) begin
        errors++;
        $display("FAIL req_busy_cnt[%0d] got=%0d exp=%0d", k, md_cnt, 10 - k);
      end
      tick();
    end
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    checks++;
    if (md_cnt !== 4'd0 || md_busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got cnt=%0d busy=%b exp cnt=0 busy=0", md_cnt, md_busy);
    end
  endtask

  task automatic test_reload_while_busy();
    drive(0, 0, 1, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    checks++;
    if (md_cnt !== 4'd5) begin
      errors++;
      $display("FAIL reload got=%0d exp=5", md_cnt);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_ctrl;
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 49) == 0);
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 9) == 0);
      exp_ctrl = model_ctrl();
      checks++;
      if ({F_en, FD_en, FD_clr, DE_clr, EM_clr, MW_req, md_start_q, md_busy} !== exp_ctrl) begin
        errors++;
        $display("FAIL rand_ctrl[%0d] got=%b exp=%b", n,
                 {F_en, FD_en, FD_clr, DE_clr, EM_clr, MW_req, md_start_q, md_busy}, exp_ctrl);
      end
      checks++;
      if (md_cnt !== 4'(model_rem()) || stall_cycles !== m_stall) begin
        errors++;
        $display("FAIL rand_state[%0d] got cnt=%0d stalls=%0d exp cnt=%0d stalls=%0d",
                 n, md_cnt, stall_cycles, model_rem(), m_stall);
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc = 0;
    m_free_at = 0;
    m_stall = 32'd0;
    reset = 1'b1;
    hz_stall = 1'b0;
    D_md_use = 1'b0;
    E_md_start = 1'b0;
    E_md_div = 1'b0;
    req = 1'b0;
    test_reset();
    test_hz_stall();
    test_div_stall();
    test_mult_no_use();
    test_flush();
    test_req_busy_reset();
    test_reload_while_busy();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
